// File: rtl/uart_frame_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_frame_pkg
// Purpose  : Shared types and helpers for the UART frame link: RX/TX state
//            encodings, the default sync word and a sync-byte extractor.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package uart_frame_pkg;

  // "abcd" in ASCII, byte 3 ('a') is sent/received first.
  localparam logic [63:0] DEFAULT_SYNC_WORD = 64'h0000_0000_6162_6364;

  typedef enum logic [1:0] {
    RX_HUNT    = 2'd0,
    RX_PAYLOAD = 2'd1,
    RX_CHECK   = 2'd2
  } rx_state_e;

  typedef enum logic [1:0] {
    TX_IDLE   = 2'd0,
    TX_PREFIX = 2'd1,
    TX_DATA   = 2'd2
  } tx_state_e;

  // Byte idx of the sync word (0 = least significant). An out-of-range
  // index shifts everything out and yields zero, which callers never use.
  function automatic logic [7:0] sync_byte(input logic [63:0] word, input int idx);
    logic [63:0] shifted;
    shifted = word >> (idx * 8);
    return shifted[7:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_frame_tx_ser.sv
`default_nettype none
// ============================================================================
// Module   : uart_frame_tx_ser
// Purpose  : Serialises a TX_BYTES result word MSB-first onto a UART byte
//            engine, optionally preceded by the sync word.
// Ports    : clk, rst_n          - clock, async active-low reset
//            tx_data_i          - result word, first byte in MSBs
//            tx_load_i          - request to send (ignored while busy)
//            tx_byte_done_i     - byte finished strobe from UART_TX
//            tx_busy_o          - serialiser not idle
//            tx_byte_o          - current byte
//            tx_byte_en_o       - level, UART_TX transmits while high
// Revision : 1.0 - initial release
// ============================================================================
module uart_frame_tx_ser
  import uart_frame_pkg::*;
#(
  parameter int          SYNC_BYTES   = 4,
  parameter logic [63:0] SYNC_WORD    = DEFAULT_SYNC_WORD,
  parameter int          TX_BYTES     = 32,
  parameter bit          TX_PREFIX_EN = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [TX_BYTES*8-1:0] tx_data_i,
  input  logic                  tx_load_i,
  input  logic                  tx_byte_done_i,
  output logic                  tx_busy_o,
  output logic [7:0]            tx_byte_o,
  output logic                  tx_byte_en_o
);

  localparam int TX_W    = TX_BYTES * 8;
  localparam int MAX_CNT = (TX_BYTES > SYNC_BYTES) ? TX_BYTES : SYNC_BYTES;
  localparam int IDX_W   = $clog2(MAX_CNT + 1);

  tx_state_e        state_q, state_d;
  logic [TX_W-1:0]  shadow_q, shadow_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       byte_q, byte_d;

  logic [TX_W-1:0]  w_shadow_shift;
  logic [7:0]       w_next_sync;
  logic             w_last_prefix;
  logic             w_last_data;

  // The shadow register shifts left as bytes go out, so its top byte is
  // always the next data byte to present.
  assign w_shadow_shift = shadow_q << 8;
  assign w_next_sync    = sync_byte(SYNC_WORD, SYNC_BYTES - 2 - int'(idx_q));
  assign w_last_prefix  = (idx_q == IDX_W'(SYNC_BYTES - 1));
  assign w_last_data    = (idx_q == IDX_W'(TX_BYTES - 1));

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    idx_d    = idx_q;
    byte_d   = byte_q;
    case (state_q)
      TX_IDLE: begin
        if (tx_load_i) begin
          shadow_d = tx_data_i;
          idx_d    = '0;
          if (TX_PREFIX_EN) begin
            state_d = TX_PREFIX;
            byte_d  = sync_byte(SYNC_WORD, SYNC_BYTES - 1);
          end else begin
            state_d = TX_DATA;
            byte_d  = tx_data_i[TX_W-1 -: 8];
          end
        end
      end
      TX_PREFIX: begin
        if (tx_byte_done_i) begin
          if (w_last_prefix) begin
            state_d = TX_DATA;
            idx_d   = '0;
            byte_d  = shadow_q[TX_W-1 -: 8];
          end else begin
            idx_d  = idx_q + IDX_W'(1);
            byte_d = w_next_sync;
          end
        end
      end
      TX_DATA: begin
        if (tx_byte_done_i) begin
          if (w_last_data) begin
            // tx_byte keeps the last value; tx_byte_en drops with the state.
            state_d = TX_IDLE;
            idx_d   = '0;
          end else begin
            idx_d    = idx_q + IDX_W'(1);
            shadow_d = w_shadow_shift;
            byte_d   = w_shadow_shift[TX_W-1 -: 8];
          end
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= TX_IDLE;
      shadow_q <= '0;
      idx_q    <= '0;
      byte_q   <= '0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      idx_q    <= idx_d;
      byte_q   <= byte_d;
    end
  end

  assign tx_busy_o    = (state_q != TX_IDLE);
  assign tx_byte_en_o = (state_q != TX_IDLE);
  assign tx_byte_o    = byte_q;

endmodule
`default_nettype wire

// File: rtl/uart_frame_link.sv
`default_nettype none
// ============================================================================
// Module   : uart_frame_link
// Purpose  : Byte-stream framer between the UART byte engines and the miner
//            core. RX hunts a sync word, assembles an RX_BYTES payload,
//            optionally checks an XOR checksum and enforces an inter-byte
//            timeout. TX serialises a result word via uart_frame_tx_ser.
// Ports    : clk, rst_n          - clock, async active-low reset
//            rx_byte_i          - byte from UART_RX
//            rx_byte_valid_i    - one-cycle strobe
//            frame_data_o       - last good payload, first byte in MSBs
//            frame_valid_o      - one-cycle pulse, new frame_data_o
//            frame_err_o        - one-cycle pulse, checksum error/timeout
//            tx_data_i          - result word to send
//            tx_load_i          - send request
//            tx_busy_o          - TX not idle
//            tx_byte_o          - byte to UART_TX
//            tx_byte_en_o       - level, UART_TX transmits while high
//            tx_byte_done_i     - byte finished strobe
// Revision : 1.0 - initial release
// ============================================================================
module uart_frame_link
  import uart_frame_pkg::*;
#(
  parameter int          SYNC_BYTES     = 4,
  parameter logic [63:0] SYNC_WORD      = DEFAULT_SYNC_WORD,
  parameter int          RX_BYTES       = 80,
  parameter int          TX_BYTES       = 32,
  parameter bit          CHECKSUM_EN    = 1'b1,
  parameter int          TIMEOUT_CYCLES = 1000000,
  parameter bit          TX_PREFIX_EN   = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            rx_byte_i,
  input  logic                  rx_byte_valid_i,
  output logic [RX_BYTES*8-1:0] frame_data_o,
  output logic                  frame_valid_o,
  output logic                  frame_err_o,
  input  logic [TX_BYTES*8-1:0] tx_data_i,
  input  logic                  tx_load_i,
  output logic                  tx_busy_o,
  output logic [7:0]            tx_byte_o,
  output logic                  tx_byte_en_o,
  input  logic                  tx_byte_done_i
);

  localparam int ASM_W  = RX_BYTES * 8;
  localparam int SIDX_W = $clog2(SYNC_BYTES + 1);
  localparam int CNT_W  = $clog2(RX_BYTES + 1);

  // --------------------------------------------------------------------------
  // RX state
  // --------------------------------------------------------------------------
  rx_state_e         rx_state_q, rx_state_d;
  logic [SIDX_W-1:0] sync_idx_q, sync_idx_d;
  logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
  logic [7:0]        xor_q, xor_d;
  logic [ASM_W-1:0]  asm_q, asm_d;
  logic [ASM_W-1:0]  frame_data_q, frame_data_d;
  logic              frame_valid_q, frame_valid_d;
  logic              frame_err_q, frame_err_d;

  logic [7:0]        w_sync_exp;
  logic [7:0]        w_sync_first;
  logic [ASM_W-1:0]  w_asm_shift;
  logic              w_in_frame;
  logic              w_timeout;

  // Sync bytes are matched from the most significant one downwards.
  assign w_sync_exp   = sync_byte(SYNC_WORD, SYNC_BYTES - 1 - int'(sync_idx_q));
  assign w_sync_first = sync_byte(SYNC_WORD, SYNC_BYTES - 1);
  assign w_asm_shift  = (asm_q << 8) | ASM_W'(rx_byte_i);
  assign w_in_frame   = (rx_state_q != RX_HUNT);

  // --------------------------------------------------------------------------
  // Inter-byte timeout. The counter holds the number of idle cycles since the
  // last byte; once it reaches TIMEOUT_CYCLES the frame is abandoned, even if
  // a byte arrives on that very cycle.
  // --------------------------------------------------------------------------
  generate
    if (TIMEOUT_CYCLES > 0) begin : g_timeout
      localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
      logic [TO_W-1:0] idle_cnt_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          idle_cnt_q <= '0;
        end else if (!w_in_frame || rx_byte_valid_i || w_timeout) begin
          idle_cnt_q <= '0;
        end else begin
          idle_cnt_q <= idle_cnt_q + TO_W'(1);
        end
      end

      assign w_timeout = w_in_frame && (idle_cnt_q == TO_W'(TIMEOUT_CYCLES));
    end else begin : g_no_timeout
      assign w_timeout = 1'b0;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // RX next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    rx_state_d    = rx_state_q;
    sync_idx_d    = sync_idx_q;
    byte_cnt_d    = byte_cnt_q;
    xor_d         = xor_q;
    asm_d         = asm_q;
    frame_data_d  = frame_data_q;
    frame_valid_d = 1'b0;
    frame_err_d   = 1'b0;

    if (w_timeout) begin
      rx_state_d  = RX_HUNT;
      sync_idx_d  = '0;
      frame_err_d = 1'b1;
    end else if (rx_byte_valid_i) begin
      case (rx_state_q)
        RX_HUNT: begin
          if (rx_byte_i == w_sync_exp) begin
            if (sync_idx_q == SIDX_W'(SYNC_BYTES - 1)) begin
              rx_state_d = RX_PAYLOAD;
              sync_idx_d = '0;
              byte_cnt_d = '0;
              xor_d      = '0;
            end else begin
              sync_idx_d = sync_idx_q + SIDX_W'(1);
            end
          end else if (rx_byte_i == w_sync_first) begin
            // A broken match may itself be the start of a new sync word.
            sync_idx_d = SIDX_W'(1);
          end else begin
            sync_idx_d = '0;
          end
        end
        RX_PAYLOAD: begin
          asm_d      = w_asm_shift;
          xor_d      = xor_q ^ rx_byte_i;
          byte_cnt_d = byte_cnt_q + CNT_W'(1);
          if (byte_cnt_q == CNT_W'(RX_BYTES - 1)) begin
            if (CHECKSUM_EN) begin
              rx_state_d = RX_CHECK;
            end else begin
              rx_state_d    = RX_HUNT;
              frame_data_d  = w_asm_shift;
              frame_valid_d = 1'b1;
            end
          end
        end
        RX_CHECK: begin
          rx_state_d = RX_HUNT;
          if (rx_byte_i == xor_q) begin
            frame_data_d  = asm_q;
            frame_valid_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end
        default: begin
          rx_state_d = RX_HUNT;
          sync_idx_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q    <= RX_HUNT;
      sync_idx_q    <= '0;
      byte_cnt_q    <= '0;
      xor_q         <= '0;
      asm_q         <= '0;
      frame_data_q  <= '0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      rx_state_q    <= rx_state_d;
      sync_idx_q    <= sync_idx_d;
      byte_cnt_q    <= byte_cnt_d;
      xor_q         <= xor_d;
      asm_q         <= asm_d;
      frame_data_q  <= frame_data_d;
      frame_valid_q <= frame_valid_d;
      frame_err_q   <= frame_err_d;
    end
  end

  assign frame_data_o  = frame_data_q;
  assign frame_valid_o = frame_valid_q;
  assign frame_err_o   = frame_err_q;

  // --------------------------------------------------------------------------
  // TX serialiser
  // --------------------------------------------------------------------------
  uart_frame_tx_ser #(
    .SYNC_BYTES   (SYNC_BYTES),
    .SYNC_WORD    (SYNC_WORD),
    .TX_BYTES     (TX_BYTES),
    .TX_PREFIX_EN (TX_PREFIX_EN)
  ) u_tx_ser (
    .clk            (clk),
    .rst_n          (rst_n),
    .tx_data_i      (tx_data_i),
    .tx_load_i      (tx_load_i),
    .tx_byte_done_i (tx_byte_done_i),
    .tx_busy_o      (tx_busy_o),
    .tx_byte_o      (tx_byte_o),
    .tx_byte_en_o   (tx_byte_en_o)
  );

endmodule
`default_nettype wire
